cic_decim_mc: RTL and testbench

CIC_DECIM_MC -- requirements
Module: cic_decim_mc

---
 rtl/cic_decim_mc.sv | 199 +++++++++++++++++++
 tb/tb_cic_decim_mc.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_decim_mc.sv
// Multichannel PDM-to-PCM CIC decimator: per-channel integrators, one time-shared comb, framed output.
// Optional macro CIC_ROUND_EN: output rounded half-up with positive saturation instead of truncated.
module cic_decim_mc #(
    parameter int CH    = 4,
    parameter int ORDER = 3,
    parameter int DECIM = 64,
    parameter int OUT_W = 16,
    localparam int W    = ORDER * $clog2(DECIM) + 2,
    localparam int CH_W = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pdm_en,
    input  logic [CH-1:0]    pdm_in,
    output logic [OUT_W-1:0] out_data,
    output logic [CH_W-1:0]  out_ch,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    input  logic             clr_ovr
);

    localparam int DEC_W = $clog2(DECIM);

    typedef enum logic [1:0] {IDLE, COMB, DRAIN} state_t;

    logic [DEC_W-1:0] dec_cnt_q;
    logic             snap;
    logic [W-1:0]     snap_all [CH];

    assign snap = pdm_en && (dec_cnt_q == DEC_W'(DECIM - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_cnt_q <= '0;
        end else if (pdm_en) begin
            dec_cnt_q <= dec_cnt_q + DEC_W'(1);
        end
    end

    // Integrators read the previous stage's registered value, so each stage adds one sample of delay.
    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_ch
            logic [W-1:0] in_ext;
            logic [W-1:0] integ_q [ORDER];
            logic [W-1:0] snap_q;

            assign in_ext      = pdm_in[gi] ? W'(1) : {W{1'b1}};
            assign snap_all[gi] = snap_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int s = 0; s < ORDER; s++) begin
                        integ_q[s] <= '0;
                    end
                    snap_q <= '0;
                end else begin
                    if (pdm_en) begin
                        integ_q[0] <= integ_q[0] + in_ext;
                        for (int s = 1; s < ORDER; s++) begin
                            integ_q[s] <= integ_q[s] + integ_q[s-1];
                        end
                    end
                    if (snap) begin
                        snap_q <= integ_q[ORDER-1];
                    end
                end
            end
        end
    endgenerate

    state_t          state_q;
    logic [CH_W-1:0] k_q;
    logic [W-1:0]    dly_q  [CH][ORDER];
    logic [OUT_W-1:0] obuf_q [CH];
    logic [W-1:0]    comb_stage [ORDER];
    logic [W-1:0]    comb_acc;
    logic [W-1:0]    comb_res;
    logic [OUT_W-1:0] word_d;
    logic [CH_W-1:0] next_k;

    logic [OUT_W-1:0] out_data_q;
    logic [CH_W-1:0]  out_ch_q;
    logic             out_last_q;
    logic             out_valid_q;
    logic             overrun_q;

    // Shared comb: the channel selected by k_q runs through all stages in one cycle.
    always_comb begin
        comb_acc = snap_all[k_q];
        for (int s = 0; s < ORDER; s++) begin
            comb_acc      = comb_acc - dly_q[k_q][s];
            comb_stage[s] = comb_acc;
        end
    end

    assign comb_res = comb_stage[ORDER-1];
    assign next_k   = k_q + CH_W'(1);

    generate
        if (OUT_W == W) begin : g_full
            assign word_d = comb_res;
        end else begin : g_narrow
            logic [OUT_W-1:0] trunc;
            assign trunc = comb_res[W-1 -: OUT_W];
`ifdef CIC_ROUND_EN
            localparam logic [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
            logic rbit;
            logic unused_lsbs;
            assign rbit        = comb_res[W-OUT_W-1];
            assign unused_lsbs = ^comb_res[W-OUT_W-1:0];
            assign word_d      = (rbit && trunc == MAX_POS) ? MAX_POS : trunc + OUT_W'(rbit);
`else
            logic unused_lsbs;
            assign unused_lsbs = ^comb_res[W-OUT_W-1:0];
            assign word_d      = trunc;
`endif
        end
    endgenerate

    // k_q is the comb channel in COMB and the presented word index in DRAIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int c = 0; c < CH; c++) begin
                obuf_q[c] <= '0;
                for (int s = 0; s < ORDER; s++) begin
                    dly_q[c][s] <= '0;
                end
            end
        end else begin
            if (clr_ovr) begin
                overrun_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (snap) begin
                        state_q <= COMB;
                        k_q     <= '0;
                    end
                end
                COMB: begin
                    obuf_q[k_q]    <= word_d;
                    dly_q[k_q][0]  <= snap_all[k_q];
                    for (int s = 1; s < ORDER; s++) begin
                        dly_q[k_q][s] <= comb_stage[s-1];
                    end
                    if (k_q == CH_W'(CH - 1)) begin
                        state_q <= DRAIN;
                        k_q     <= '0;
                    end else begin
                        k_q <= next_k;
                    end
                end
                DRAIN: begin
                    if (snap) begin
                        overrun_q   <= 1'b1;
                        state_q     <= COMB;
                        k_q         <= '0;
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                    end else if (!out_valid_q) begin
                        out_data_q  <= obuf_q[k_q];
                        out_ch_q    <= k_q;
                        out_last_q  <= (k_q == CH_W'(CH - 1));
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        if (out_last_q) begin
                            state_q     <= IDLE;
                            k_q         <= '0;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                        end else begin
                            out_data_q <= obuf_q[next_k];
                            out_ch_q   <= next_k;
                            out_last_q <= (next_k == CH_W'(CH - 1));
                            k_q        <= next_k;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_cic_decim_mc.sv
// Scoreboard bench for cic_decim_mc: stimulus pushes expected words, a negedge monitor pops on each transfer.
module tb_cic_decim_mc;

    localparam int CH    = 4;
    localparam int ORDER = 3;
    localparam int DECIM = 64;
    localparam int OUT_W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          pdm_en;
    logic [CH-1:0] pdm_in;
    logic [OUT_W-1:0] out_data;
    logic [1:0]    out_ch;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;
    logic          overrun;
    logic          clr_ovr;

    always #5 clk = ~clk;

    cic_decim_mc #(.CH(CH), .ORDER(ORDER), .DECIM(DECIM), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .pdm_en    (pdm_en),
        .pdm_in    (pdm_in),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun),
        .clr_ovr   (clr_ovr)
    );

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  ch;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   snap_cyc = 0;
    int   gpulse = 0;
    bit   lat_chk = 1'b0;

    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [15:0] prev_data = '0;
    logic [1:0]  prev_ch = '0;
    logic        prev_last = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expected words for frame f (1-based) after reset; transient frames 1..3 derived from the closed-form integrator sums.
    function automatic logic [15:0] exp_word(input int mode, input int ch, input int f);
        int ones  [4] = '{2481, 13390, 16383, 16384};
        int zeros [4] = '{-2482, -13391, -16384, -16384};
        int tog   [4] = '{60, 67, 0, 0};
        int k;
        k = (f > 4) ? 3 : f - 1;
        if (mode == 1) return 16'(zeros[k]);
        if (mode == 2 && ch == 0) return 16'(tog[k]);
        return 16'(ones[k]);
    endfunction

    task automatic push_frame(input int mode, input int f);
        for (int c = 0; c < CH; c++) begin
            exp_t e;
            e.data = exp_word(mode, c, f);
            e.ch   = 2'(c);
            e.last = (c == CH - 1);
            sb.push_back(e);
        end
    endtask

    task automatic pulse(input logic [CH-1:0] bits, input bit is_snap, input bit clr);
        @(posedge clk); #1;
        pdm_en  = 1'b1;
        pdm_in  = bits;
        clr_ovr = clr;
        if (is_snap) snap_cyc = cyc + 1;
        @(posedge clk); #1;
        pdm_en  = 1'b0;
        clr_ovr = 1'b0;
        repeat (6) @(posedge clk);
    endtask

    task automatic run_frame(input int mode, input int f, input bit push, input bit clr_at_snap);
        for (int p = 0; p < DECIM; p++) begin
            logic [CH-1:0] bits;
            case (mode)
                0:       bits = '1;
                1:       bits = '0;
                default: bits = {3'b111, ~gpulse[0]};
            endcase
            if (p == DECIM - 1 && push) push_frame(mode, f);
            pulse(bits, p == DECIM - 1, clr_at_snap && p == DECIM - 1);
            gpulse++;
        end
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        check("queue_empty", sb.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        sb.delete();
        gpulse = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk); #1;
        out_ready = v;
    endtask

    // Monitor: stability under backpressure, snap-to-valid latency, and scoreboard compare on each transfer.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (prev_valid && !prev_ready && out_valid) begin
                check("hold_data", out_data, prev_data);
                check("hold_ch", out_ch, prev_ch);
                check("hold_last", out_last, prev_last);
            end
            if (lat_chk && out_valid && !prev_valid) begin
                check("latency", cyc - snap_cyc, 5);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got ch=%0d data=%h, want none", out_ch, out_data);
                end else begin
                    e = sb.pop_front();
                    check("data", out_data, e.data);
                    check("ch", out_ch, e.ch);
                    check("last", out_last, e.last);
                    $display("xfer ch=%0d data=%h last=%0d exp=%h", out_ch, out_data, out_last, e.data);
                end
            end
        end
        prev_valid = out_valid;
        prev_ready = out_ready;
        prev_data  = out_data;
        prev_ch    = out_ch;
        prev_last  = out_last;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        bit found;
        rst       = 1'b1;
        pdm_en    = 1'b0;
        pdm_in    = '0;
        clr_ovr   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_ch", out_ch, 0);
        check("rst_last", out_last, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;

        // All ones
        for (int f = 1; f <= 5; f++) run_frame(0, f, 1'b1, 1'b0);
        wait_empty();
        do_reset();

        // All zeros
        for (int f = 1; f <= 5; f++) run_frame(1, f, 1'b1, 1'b0);
        wait_empty();
        do_reset();

        // ch0 toggling, others ones; latency from snap edge checked on every frame
        lat_chk = 1'b1;
        for (int f = 1; f <= 5; f++) run_frame(2, f, 1'b1, 1'b0);
        wait_empty();
        lat_chk = 1'b0;
        do_reset();

        // Backpressure across two snaps
        set_ready(1'b0);
        run_frame(0, 1, 1'b0, 1'b0);
        @(negedge clk);
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, 16'd2481);
        check("stall_ch", out_ch, 0);
        check("stall_ovr", overrun, 0);
        run_frame(0, 2, 1'b0, 1'b0);
        @(negedge clk);
        check("ovr_set", overrun, 1);
        check("ovr_valid", out_valid, 1);
        check("ovr_replaced", out_data, 16'd13390);
        check("ovr_ch", out_ch, 0);
        push_frame(0, 2);
        set_ready(1'b1);
        wait_empty();
        @(posedge clk); #1 clr_ovr = 1'b1;
        @(posedge clk); #1 clr_ovr = 1'b0;
        @(negedge clk);
        check("ovr_cleared", overrun, 0);
        set_ready(1'b0);
        run_frame(0, 3, 1'b0, 1'b0);
        @(negedge clk);
        check("stall3_ovr", overrun, 0);
        check("stall3_data", out_data, 16'd16383);
        run_frame(0, 4, 1'b0, 1'b1);
        @(negedge clk);
        check("ovr_clr_coincident", overrun, 1);
        push_frame(0, 4);
        set_ready(1'b1);
        wait_empty();
        do_reset();

        // Reset while word 2 is presented
        run_frame(0, 1, 1'b1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (out_valid && out_ch == 2'd2) found = 1'b1;
        end
        check("word2_seen", found, 1);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_data", out_data, 0);
        sb.delete();
        gpulse = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int f = 1; f <= 5; f++) run_frame(0, f, 1'b1, 1'b0);
        wait_empty();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
